// File: rtl/serial_mag_comp.sv
// Bit-serial magnitude comparator: walks the captured operands MSB first and
// stops at the first differing bit, with optional two's-complement treatment of the MSB.
module serial_mag_comp #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             Eq,
    output logic             Gt,
    output logic             Lt
);

    localparam int unsigned        IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]   IDX_MSB = IDX_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CMP  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sgn_q, sgn_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;

    logic               a_bit_c;
    logic               b_bit_c;
    logic               bit_diff_c;
    logic               last_bit_c;
    logic               msb_signed_c;

    assign a_bit_c      = a_q[idx_q];
    assign b_bit_c      = b_q[idx_q];
    assign bit_diff_c   = a_bit_c ^ b_bit_c;
    assign last_bit_c   = (idx_q == '0);
    // Sign bit has inverted weight in two's complement, so its sense flips.
    assign msb_signed_c = sgn_q & (idx_q == IDX_MSB);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= IDX_MSB;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_CMP;
            S_CMP:  if (bit_diff_c || last_bit_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, index walk and result flags.
    always_comb begin
        idx_d  = idx_q;
        a_d    = a_q;
        b_d    = b_q;
        sgn_d  = sgn_q;
        done_d = 1'b0;
        eq_d   = eq_q;
        gt_d   = gt_q;
        lt_d   = lt_q;
        busy_d = (state_d == S_CMP);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = A;
                    b_d   = B;
                    sgn_d = signed_mode & SIGNED_EN;
                    idx_d = IDX_MSB;
                end
            end
            S_CMP: begin
                if (bit_diff_c) begin
                    done_d = 1'b1;
                    eq_d   = 1'b0;
                    gt_d   = msb_signed_c ? ~a_bit_c : a_bit_c;
                    lt_d   = msb_signed_c ? a_bit_c : ~a_bit_c;
                end else if (last_bit_c) begin
                    done_d = 1'b1;
                    eq_d   = 1'b1;
                    gt_d   = 1'b0;
                    lt_d   = 1'b0;
                end else begin
                    idx_d = IDX_W'(idx_q - 1'b1);
                end
            end
            default: ;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Eq   = eq_q;
    assign Gt   = gt_q;
    assign Lt   = lt_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed bench for serial_mag_comp: 8-bit scenarios plus an exhaustive
// 4-bit sweep in both modes, each checked against hand or arithmetic results.
module tb_serial_mag_comp;

    logic       clk;
    logic       rst;
    logic       signed_mode;
    logic       start8, start4;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;
    logic       busy8, done8, eq8, gt8, lt8;
    logic       busy4, done4, eq4, gt4, lt4;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [2:0] F_EQ = 3'b100;
    localparam logic [2:0] F_GT = 3'b010;
    localparam logic [2:0] F_LT = 3'b001;

    serial_mag_comp #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(signed_mode),
        .A(a8), .B(b8), .busy(busy8), .done(done8), .Eq(eq8), .Gt(gt8), .Lt(lt8)
    );

    serial_mag_comp #(.WIDTH(4), .SIGNED_EN(1'b1)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(signed_mode),
        .A(a4), .B(b4), .busy(busy4), .done(done4), .Eq(eq4), .Gt(gt4), .Lt(lt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one compare and follow it to its done pulse; returns in the done cycle.
    task automatic do_cmp(input bit w4, input logic [7:0] a, input logic [7:0] b,
                          input bit sm, input logic [2:0] exp_f, input int exp_lat,
                          input string tag);
        int k;
        int busy_cnt;
        logic d_o, b_o;
        signed_mode = sm;
        if (w4) begin a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1; end
        else    begin a8 = a;      b8 = b;      start8 = 1'b1; end
        tick();
        start4 = 1'b0;
        start8 = 1'b0;
        k = 0;
        busy_cnt = 0;
        d_o = w4 ? done4 : done8;
        b_o = w4 ? busy4 : busy8;
        while (k < 20 && !d_o) begin
            if (b_o) busy_cnt++;
            tick();
            k++;
            d_o = w4 ? done4 : done8;
            b_o = w4 ? busy4 : busy8;
        end
        check({tag, " latency"}, 32'(k), 32'(exp_lat));
        check({tag, " flags"}, w4 ? 32'({eq4, gt4, lt4}) : 32'({eq8, gt8, lt8}), 32'(exp_f));
        check({tag, " busy_in_done"}, 32'(b_o), 32'd0);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    endtask

    initial begin
        int dones;
        int first_done;
        int sa, sb, lat;
        logic [2:0] ef;
        logic [3:0] x;

        rst = 1'b1;
        signed_mode = 1'b0;
        start4 = 1'b1;
        start8 = 1'b1;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        a4 = 4'($urandom);
        b4 = 4'($urandom);

        // Reset held for two edges with start asserted.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst busy", 32'(busy8), 32'd0);
            check("rst done", 32'(done8), 32'd0);
            check("rst flags", 32'({eq8, gt8, lt8}), 32'd0);
            check("rst4 flags", 32'({busy4, done4, eq4, gt4, lt4}), 32'd0);
        end
        rst = 1'b0;
        start4 = 1'b0;
        start8 = 1'b0;
        tick();
        check("idle busy", 32'(busy8), 32'd0);

        do_cmp(1'b0, 8'h80, 8'h7F, 1'b0, F_GT, 1, "u80_7f");
        do_cmp(1'b0, 8'h80, 8'h7F, 1'b1, F_LT, 1, "s80_7f");

        // Equal operands; changed inputs and a second start during CMP are ignored.
        signed_mode = 1'b0;
        a8 = 8'h5A;
        b8 = 8'h5A;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        a8 = 8'h00;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        dones = 0;
        first_done = -1;
        for (int k = 2; k < 16; k++) begin
            if (done8) begin
                dones++;
                if (first_done < 0) begin
                    first_done = k;
                    check("eq5a flags", 32'({eq8, gt8, lt8}), 32'(F_EQ));
                end
            end
            if (done8 && busy8) check("eq5a done_busy", 32'd1, 32'd0);
            tick();
        end
        check("eq5a latency", 32'(first_done), 32'd8);
        check("eq5a done_count", 32'(dones), 32'd1);

        // Back-to-back: second start issued in the done cycle of the first.
        do_cmp(1'b0, 8'h12, 8'h13, 1'b0, F_LT, 8, "b2b_first");
        do_cmp(1'b0, 8'hF0, 8'h0F, 1'b0, F_GT, 1, "b2b_second");
        tick();

        // Reset during the third CMP cycle aborts without a done pulse.
        a8 = 8'h01;
        b8 = 8'h02;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        check("abort pre done", 32'(done8), 32'd0);
        tick();
        check("abort pre busy", 32'(busy8), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort flags", 32'({busy8, done8, eq8, gt8, lt8}), 32'd0);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            if (done8) dones++;
            tick();
        end
        check("abort no_done", 32'(dones), 32'd0);
        do_cmp(1'b0, 8'h03, 8'h03, 1'b0, F_EQ, 8, "post_rst_eq");

        // Exhaustive 4-bit sweep in unsigned and signed mode.
        for (int sm = 0; sm < 2; sm++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    sa = (sm == 1 && a >= 8) ? a - 16 : a;
                    sb = (sm == 1 && b >= 8) ? b - 16 : b;
                    ef = (sa == sb) ? F_EQ : (sa > sb) ? F_GT : F_LT;
                    x = 4'(a ^ b);
                    lat = x[3] ? 1 : x[2] ? 2 : x[1] ? 3 : 4;
                    do_cmp(1'b1, 8'(a), 8'(b), 1'(sm), ef, lat,
                           $sformatf("w4 sm%0d a%0h b%0h", sm, a, b));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_mag_comp.md
SERIAL_MAG_COMP -- requirements
Module: serial_mag_comp

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have parameter SIGNED_EN, default 1; when set, the signed_mode input is honoured, and when 0 it is ignored (unsigned compare always).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a compare; sampled only in IDLE.
REQ-006 SHALL have port signed_mode, input, 1 bit: 1 means two's-complement compare; captured with start.
REQ-007 SHALL have port A, input, WIDTH bits: operand A; captured with start.
REQ-008 SHALL have port B, input, WIDTH bits: operand B; captured with start.
REQ-009 SHALL have port busy, output, 1 bit: high while in CMP.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a result is written.
REQ-011 SHALL have ports Eq, Gt and Lt, each output, 1 bit: registered result flags, held until the next done or reset.

Function
REQ-012 SHALL implement states IDLE and CMP, plus a bit index register idx of width clog2(WIDTH).
REQ-013 IDLE behaviour SHALL be: on an edge with start=1, capture A, B and signed_mode (AND SIGNED_EN) into internal registers, load idx=WIDTH-1, and go to CMP.
REQ-014 IDLE SHALL otherwise hold state.
REQ-015 CMP SHALL compare captured bit A[idx] with B[idx] on each edge, MSB first, one bit per cycle.
REQ-016 If the CMP bits differ and idx=WIDTH-1 with signed mode active, the result SHALL be: A bit 1 gives Lt=1, and A bit 0 gives Gt=1.
REQ-017 In all other CMP cases where the bits differ, the result SHALL be: A bit 1 gives Gt=1, and A bit 0 gives Lt=1.
REQ-018 Early termination SHALL apply: on the first differing bit, write the flags, assert done for the following cycle, and return to IDLE; the remaining bits are not examined.
REQ-019 If bits are equal and idx=0, CMP SHALL write Eq=1, assert done, and return to IDLE.
REQ-020 If bits are equal and idx>0, CMP SHALL decrement idx and stay in CMP.
REQ-021 Latency SHALL be as follows: with start sampled at edge N and j leading equal bits, done is high in the cycle after edge N+1+j (j=0..WIDTH-1); equal operands give done after edge N+WIDTH.
REQ-022 Eq, Gt and Lt SHALL be exactly one-hot after any done, and all SHALL be written on the same edge that raises done.
REQ-023 Input changes on A, B and signed_mode during CMP SHALL have no effect on the result in progress.
REQ-024 start=1 while in CMP SHALL be ignored, with no queuing.
REQ-025 start=1 in the cycle where done is high SHALL be accepted, because the state is IDLE; back-to-back compares therefore need no idle gap.
REQ-026 busy SHALL be high exactly in the cycles where the state is CMP.
REQ-027 done and busy SHALL never be high in the same cycle.
REQ-028 With SIGNED_EN=0, the MSB SHALL be treated as unsigned regardless of signed_mode.

Reset
REQ-029 An rst=1 edge SHALL force IDLE, idx=WIDTH-1, busy=0, done=0, Eq=0, Gt=0 and Lt=0, and clear the captured operands.
REQ-030 rst SHALL have priority over start and over any CMP decision on the same edge.
REQ-031 Reset mid-CMP SHALL abort the compare with no done pulse; the next start after rst falls SHALL behave normally.

Verification (WIDTH=8, SIGNED_EN=1)
REQ-032 The bench SHALL drive rst=1 for 2 edges with random A and B and start=1 -> required response: busy=0, done=0, Eq=Gt=Lt=0 throughout.
REQ-033 The bench SHALL drive A=0x80, B=0x7F, signed_mode=0 and pulse start at edge N -> required response: done high after edge N+1 only, Gt=1, busy high for 1 cycle.
REQ-034 The bench SHALL repeat REQ-033 with signed_mode=1 -> required response: done after edge N+1, Lt=1, Gt=0, Eq=0.
REQ-035 The bench SHALL drive A=B=0x5A and start at edge N, then change A to 0x00 and pulse start again during CMP -> required response: single done after edge N+8, Eq=1, and the second start ignored.
REQ-036 The bench SHALL drive A=0x12, B=0x13 unsigned, with a second start (A=0xF0, B=0x0F) in the done cycle -> required response: first done after edge N+8 with Lt=1, second done exactly 2 cycles later with Gt=1.
REQ-037 The bench SHALL drive A=0x01, B=0x02, assert rst on the 3rd CMP cycle, then start A=0x03, B=0x03 -> required response: no done for the aborted compare, flags 0 after reset, and the later compare ends with Eq=1 after 8 compare cycles.
REQ-038 The bench SHALL run an exhaustive sweep of all A,B pairs for WIDTH=4 in both modes -> required response: flags match the arithmetic compare, and done latency matches REQ-021 for every pair.
